shift_ctrl_8b: RTL and testbench
================================

SHIFT_CTRL_8B -- requirements
Module: shift_ctrl_8b

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
- CLK  input  1  clock; all state changes on the rising edge.
- CLRb  input  1  asynchronous active-low clear.
- START  input  1  command strobe; accepted only when READY=1.
- LOAD  input  1  command field; 1 = parallel-load DIN before shifting.
- DIR  input  1  command field; 0 = shift right, 1 = shift left.
- AMT  input  3  command field; shift count, 0..7.
- FILL  input  1  command field; serial fill bit.
- ROT  input  1  command field; 1 = rotate instead of fill.
- DIN  input  8  load value.
- HOLD  input  1  pause request.
- QIN  input  8  Q from the downstream shift_reg_8b.
- READY  output  1  idle; a command may be issued.
- DONE  output  1  one-cycle completion pulse.
- S  output  2  mode to shift_reg_8b:
  - 00 hold
  - 01 right, Q <= {SDR,Q[7:1]}
  - 10 left, Q <= {Q[6:0],SDL}
  - 11 load D.
- SDL, SDR  output  1 each  serial inputs to shift_reg_8b.
- D  output  8  parallel data to shift_reg_8b.

Function
REQ-002 On START=1 with READY=1 at a rising edge, the block SHALL capture LOAD, DIR, AMT, FILL, ROT and DIN, then leave IDLE.
REQ-003 START while READY=0 SHALL be ignored; no queuing.
REQ-004 FSM states SHALL be IDLE, LOADP, SHIFT and DONEP.
- IDLE -> LOADP if LOAD=1.
- IDLE -> SHIFT if LOAD=0 and AMT>0.
- IDLE -> DONEP if LOAD=0 and AMT=0.
- LOADP -> SHIFT if AMT>0, else DONEP.
- SHIFT -> DONEP after AMT non-held cycles.
- DONEP -> IDLE.
REQ-005 S SHALL be decoded from the state register as follows:
- LOADP: 11.
- SHIFT with HOLD=0: 01 if DIR=0, 10 if DIR=1.
- SHIFT with HOLD=1: 00.
- IDLE and DONEP: 00.
REQ-006 In SHIFT, a 3-bit down-counter loaded with AMT SHALL decrement only on non-held cycles.
REQ-007 SHIFT SHALL exit to DONEP on the edge at which the counter goes 1->0.
REQ-008 HOLD SHALL be ignored outside SHIFT.
REQ-009 D SHALL equal the captured DIN from the accept edge until the next accept; D is 00 after reset.
REQ-010 While a right shift is active, SDR SHALL equal the captured FILL (or QIN[0] when rotating per REQ-016) and SDL SHALL be 0.
REQ-011 While a left shift is active, SDL SHALL equal the captured FILL (or QIN[7] when rotating per REQ-016) and SDR SHALL be 0.
REQ-012 Outside an active shift, SDL and SDR SHALL both be 0.
REQ-013 READY SHALL be 1 only in IDLE, and DONE SHALL be 1 only in DONEP.
REQ-014 Latency from the accept edge to DONE high SHALL be LOAD + AMT + (held cycles) + 1 cycles; the minimum is 1, for LOAD=0 and AMT=0.

Reset
REQ-015 CLRb=0 SHALL immediately, at any time including mid-command, set the following, aborting any command:
- state = IDLE
- counter = 0
- S = 00
- SDL = SDR = 0
- D = 00
- READY = 1
- DONE = 0

Configuration
REQ-016 With SHIFT_CTRL_ROTATE_EN defined, captured ROT=1 SHALL make the serial bit QIN[0] for right shifts and QIN[7] for left shifts, replacing FILL.
REQ-017 Without SHIFT_CTRL_ROTATE_EN, ports ROT and QIN SHALL remain present but be ignored, and FILL is always used.

Structure
REQ-018 Package shift_ctrl_pkg SHALL hold:
- state encoding constants
- S-code constants S_HOLD, S_SHR, S_SHL, S_LOAD.
REQ-019 The down-counter SHALL be a sub-module shift_cnt_3b with load, enable and zero-flag.

Verification
REQ-020 The bench SHALL instantiate shift_ctrl_8b driving shift_reg_8b on shared CLK/CLRb, and SHALL cover:
- CLRb=0 -> READY=1, S=00, D=00, Q=00.
- START, LOAD=1, DIN=2E, AMT=0 -> S=11 for one cycle, then Q=2E, DONE one cycle later; latency 2.
- LOAD=1, DIN=2E, DIR=1, AMT=3, FILL=1 -> Q sequence 2E, 5D, BB, 77; DONE at latency 5.
- Then LOAD=0, DIR=0, AMT=2, FILL=0 -> Q 77, 3B, 1D; START pulsed mid-shift is ignored.
- SHIFT_CTRL_ROTATE_EN defined, LOAD=1, DIN=2E, ROT=1, DIR=0, AMT=4 -> Q=E2; without the macro, same stimulus with FILL=0 -> Q=02.
- HOLD=1 for 3 cycles mid-shift -> S=00, Q frozen, DONE delayed by 3; CLRb pulse mid-SHIFT -> READY=1 at once, S=00.

Source files
------------

// File: rtl/shift_ctrl_pkg.sv
// Shared state encoding and shift_reg_8b mode codes for the shift controller.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOADP = 2'd1,
        SHIFT = 2'd2,
        DONEP = 2'd3
    } state_e;

    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_SHR  = 2'b01;
    localparam logic [1:0] S_SHL  = 2'b10;
    localparam logic [1:0] S_LOAD = 2'b11;

endpackage

// File: rtl/shift_cnt_3b.sv
// 3-bit loadable down-counter with enable and zero flag; saturates at zero.
module shift_cnt_3b (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       en_i,
    output logic [2:0] cnt_o,
    output logic       zero_o
);

    logic [2:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == 3'd0);

endmodule

// File: rtl/shift_reg_8b.sv
// 8-bit universal shift register driven by shift_ctrl_8b (hold/right/left/load).
module shift_reg_8b
    import shift_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       CLRb,
    input  logic [1:0] S,
    input  logic       SDL,
    input  logic       SDR,
    input  logic [7:0] D,
    output logic [7:0] Q
);

    logic [7:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        case (S)
            S_SHR:   q_d = {SDR, q_q[7:1]};
            S_SHL:   q_d = {q_q[6:0], SDL};
            S_LOAD:  q_d = D;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge CLK or negedge CLRb) begin
        if (!CLRb) begin
            q_q <= 8'h00;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/shift_ctrl_8b.sv
// Command sequencer for shift_reg_8b: optional load, then AMT shifts with HOLD pause.
// Define SHIFT_CTRL_ROTATE_EN to let ROT select QIN[0]/QIN[7] as the serial bit.
module shift_ctrl_8b
    import shift_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       CLRb,
    input  logic       START,
    input  logic       LOAD,
    input  logic       DIR,
    input  logic [2:0] AMT,
    input  logic       FILL,
    input  logic       ROT,
    input  logic [7:0] DIN,
    input  logic       HOLD,
    input  logic [7:0] QIN,
    output logic       READY,
    output logic       DONE,
    output logic [1:0] S,
    output logic       SDL,
    output logic       SDR,
    output logic [7:0] D
);

    state_e     state_d, state_q;
    logic       dir_q, fill_q;
    logic [7:0] d_q;
    logic       accept;
    logic       cnt_load, cnt_en, cnt_zero;
    logic [2:0] cnt_val;
    logic       ser_r, ser_l;

    assign accept = (state_q == IDLE) && START;

`ifdef SHIFT_CTRL_ROTATE_EN
    logic rot_q;

    always_ff @(posedge CLK or negedge CLRb) begin
        if (!CLRb) begin
            rot_q <= 1'b0;
        end else if (accept) begin
            rot_q <= ROT;
        end
    end

    assign ser_r = rot_q ? QIN[0] : fill_q;
    assign ser_l = rot_q ? QIN[7] : fill_q;
`else
    logic unused_rot_qin;

    assign unused_rot_qin = ^{ROT, QIN};
    assign ser_r = fill_q;
    assign ser_l = fill_q;
`endif

    always_ff @(posedge CLK or negedge CLRb) begin
        if (!CLRb) begin
            dir_q  <= 1'b0;
            fill_q <= 1'b0;
            d_q    <= 8'h00;
        end else if (accept) begin
            dir_q  <= DIR;
            fill_q <= FILL;
            d_q    <= DIN;
        end
    end

    // Counter is loaded with AMT at accept so LOADP can branch on its zero flag.
    shift_cnt_3b u_cnt (
        .clk_i      (CLK),
        .rst_ni     (CLRb),
        .load_i     (cnt_load),
        .load_val_i (AMT),
        .en_i       (cnt_en),
        .cnt_o      (cnt_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        S        = S_HOLD;
        SDL      = 1'b0;
        SDR      = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    cnt_load = 1'b1;
                    if (LOAD) begin
                        state_d = LOADP;
                    end else if (AMT != 3'd0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d = DONEP;
                    end
                end
            end
            LOADP: begin
                S       = S_LOAD;
                state_d = cnt_zero ? DONEP : SHIFT;
            end
            SHIFT: begin
                if (!HOLD) begin
                    cnt_en = 1'b1;
                    if (dir_q) begin
                        S   = S_SHL;
                        SDL = ser_l;
                    end else begin
                        S   = S_SHR;
                        SDR = ser_r;
                    end
                    if (cnt_val == 3'd1) begin
                        state_d = DONEP;
                    end
                end
            end
            DONEP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLRb) begin
        if (!CLRb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign READY = (state_q == IDLE);
    assign DONE  = (state_q == DONEP);
    assign D     = d_q;

endmodule

// File: tb/tb_shift_ctrl_8b.sv
// Directed bench: shift_ctrl_8b driving shift_reg_8b, expected values computed by hand.
module tb_shift_ctrl_8b;

    logic       CLK;
    logic       CLRb;
    logic       START, LOAD, DIR, FILL, ROT, HOLD;
    logic [2:0] AMT;
    logic [7:0] DIN;
    logic [7:0] Q;
    logic       READY, DONE, SDL, SDR;
    logic [1:0] S;
    logic [7:0] D;

    int n_asserts = 0;
    int n_fail    = 0;

    shift_ctrl_8b dut (
        .CLK   (CLK),
        .CLRb  (CLRb),
        .START (START),
        .LOAD  (LOAD),
        .DIR   (DIR),
        .AMT   (AMT),
        .FILL  (FILL),
        .ROT   (ROT),
        .DIN   (DIN),
        .HOLD  (HOLD),
        .QIN   (Q),
        .READY (READY),
        .DONE  (DONE),
        .S     (S),
        .SDL   (SDL),
        .SDR   (SDR),
        .D     (D)
    );

    shift_reg_8b u_sr (
        .CLK  (CLK),
        .CLRb (CLRb),
        .S    (S),
        .SDL  (SDL),
        .SDR  (SDR),
        .D    (D),
        .Q    (Q)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Present a command, let the accept edge take it, drop START.
    task automatic issue(input logic ld, input logic dr, input logic [2:0] amt,
                         input logic fl, input logic rt, input logic [7:0] din);
        LOAD  = ld;
        DIR   = dr;
        AMT   = amt;
        FILL  = fl;
        ROT   = rt;
        DIN   = din;
        START = 1'b1;
        tick();
        START = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] rot_exp;
        logic [7:0] rot_sdr;
`ifdef SHIFT_CTRL_ROTATE_EN
        rot_exp = 8'hE2;
        rot_sdr = 8'h01;
`else
        rot_exp = 8'h02;
        rot_sdr = 8'h00;
`endif
        CLRb  = 1'b0;
        START = 1'b0;
        LOAD  = 1'b0;
        DIR   = 1'b0;
        AMT   = 3'd0;
        FILL  = 1'b0;
        ROT   = 1'b0;
        DIN   = 8'h00;
        HOLD  = 1'b0;
        #12;
        chk("rst_ready", {7'd0, READY}, 8'h01);
        chk("rst_done", {7'd0, DONE}, 8'h00);
        chk("rst_s", {6'd0, S}, 8'h00);
        chk("rst_d", D, 8'h00);
        chk("rst_q", Q, 8'h00);
        CLRb = 1'b1;
        tick();

        // Load only, AMT=0: latency 2.
        issue(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'h2E);
        chk("ld0_s_load", {6'd0, S}, 8'h03);
        chk("ld0_ready", {7'd0, READY}, 8'h00);
        chk("ld0_done_early", {7'd0, DONE}, 8'h00);
        chk("ld0_d", D, 8'h2E);
        tick();
        chk("ld0_q", Q, 8'h2E);
        chk("ld0_done", {7'd0, DONE}, 8'h01);
        chk("ld0_s_hold", {6'd0, S}, 8'h00);
        tick();
        chk("ld0_idle", {7'd0, READY}, 8'h01);
        chk("ld0_done_pulse", {7'd0, DONE}, 8'h00);

        // Load 2E then left by 3 with fill 1: latency 5.
        issue(1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 8'h2E);
        chk("l3_s_load", {6'd0, S}, 8'h03);
        tick();
        chk("l3_q0", Q, 8'h2E);
        chk("l3_s_shl", {6'd0, S}, 8'h02);
        chk("l3_sdl", {7'd0, SDL}, 8'h01);
        chk("l3_sdr", {7'd0, SDR}, 8'h00);
        tick();
        chk("l3_q1", Q, 8'h5D);
        tick();
        chk("l3_q2", Q, 8'hBB);
        chk("l3_done_early", {7'd0, DONE}, 8'h00);
        tick();
        chk("l3_q3", Q, 8'h77);
        chk("l3_done", {7'd0, DONE}, 8'h01);
        chk("l3_sdl_off", {7'd0, SDL}, 8'h00);
        tick();
        chk("l3_idle", {7'd0, READY}, 8'h01);

        // No load, right by 2 fill 0; mid-shift START must be ignored.
        issue(1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 8'hA5);
        chk("r2_d", D, 8'hA5);
        chk("r2_q0", Q, 8'h77);
        chk("r2_s_shr", {6'd0, S}, 8'h01);
        LOAD  = 1'b1;
        DIN   = 8'hFF;
        START = 1'b1;
        tick();
        START = 1'b0;
        #1;
        chk("r2_q1", Q, 8'h3B);
        tick();
        chk("r2_q2", Q, 8'h1D);
        chk("r2_done", {7'd0, DONE}, 8'h01);
        chk("r2_d_kept", D, 8'hA5);
        tick();
        chk("r2_idle", {7'd0, READY}, 8'h01);
        chk("r2_no_queue", {6'd0, S}, 8'h00);
        tick();
        chk("r2_still_idle", {7'd0, READY}, 8'h01);
        chk("r2_q_kept", Q, 8'h1D);

        // Load 2E, right by 4 with ROT=1 FILL=0.
        issue(1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 8'h2E);
        tick();
        chk("rot_q0", Q, 8'h2E);
        chk("rot_sdr0", {7'd0, SDR}, 8'h00);
        tick();
        chk("rot_q1", Q, 8'h17);
        chk("rot_sdr1", {7'd0, SDR}, rot_sdr);
        tick();
        tick();
        tick();
        chk("rot_q4", Q, rot_exp);
        chk("rot_done", {7'd0, DONE}, 8'h01);
        tick();

        // Load 81, left by 2, HOLD for 3 shift cycles: latency 7.
        issue(1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 8'h81);
        HOLD = 1'b1;
        #1;
        chk("hold_ignored_loadp", {6'd0, S}, 8'h03);
        tick();
        chk("hold_q_load", Q, 8'h81);
        chk("hold_s", {6'd0, S}, 8'h00);
        chk("hold_sdl", {7'd0, SDL}, 8'h00);
        tick();
        tick();
        tick();
        chk("hold_q_frozen", Q, 8'h81);
        chk("hold_not_done", {7'd0, DONE}, 8'h00);
        HOLD = 1'b0;
        #1;
        chk("hold_release_s", {6'd0, S}, 8'h02);
        tick();
        chk("hold_q1", Q, 8'h02);
        chk("hold_done_early", {7'd0, DONE}, 8'h00);
        tick();
        chk("hold_q2", Q, 8'h04);
        chk("hold_done", {7'd0, DONE}, 8'h01);
        tick();

        // CLRb pulse in the middle of a right shift by 5.
        issue(1'b0, 1'b0, 3'd5, 1'b1, 1'b0, 8'h3C);
        chk("clr_sdr_fill", {7'd0, SDR}, 8'h01);
        tick();
        chk("clr_q1", Q, 8'h82);
        #2;
        CLRb = 1'b0;
        #1;
        chk("clr_ready", {7'd0, READY}, 8'h01);
        chk("clr_s", {6'd0, S}, 8'h00);
        chk("clr_sdr", {7'd0, SDR}, 8'h00);
        chk("clr_d", D, 8'h00);
        chk("clr_q", Q, 8'h00);
        chk("clr_done", {7'd0, DONE}, 8'h00);
        #1;
        CLRb = 1'b1;
        tick();
        chk("clr_stay_idle", {7'd0, READY}, 8'h01);

        // Minimum latency: LOAD=0 AMT=0 gives DONE right after the accept edge.
        issue(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'h5A);
        chk("min_done", {7'd0, DONE}, 8'h01);
        chk("min_s", {6'd0, S}, 8'h00);
        chk("min_d", D, 8'h5A);
        tick();
        chk("min_idle", {7'd0, READY}, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
